// File: rtl/ram_moc_responder.sv
// Memory-side responder for the MOV/RW/MOC handshake: a big-endian byte array with
// byte/halfword/word access after a fixed number of wait states.
module ram_moc_responder #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  Type,
  input  logic        SE,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        Err
);

  localparam int unsigned Depth  = 1 << ADDR_W;
  localparam logic [3:0]  LpWait = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              r_state, w_state_nx;
  logic [3:0]          r_cnt, w_cnt_nx;
  logic                r_rw, r_se;
  logic [1:0]          r_type;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_dout, w_dout_nx;
  logic                r_moc, w_moc_nx;
  logic                r_err, w_err_nx;
  logic                w_latch, w_we;
  logic [7:0]          r_mem [Depth];

  logic [ADDR_W-1:0]   w_a1, w_a2, w_a3;
  logic [7:0]          w_b0, w_b1, w_b2, w_b3;
  logic [31:0]         w_rdata;
  logic                w_fault;
  logic                w_unused_addr;

  assign w_unused_addr = ^Address[31:ADDR_W];

  // Byte offsets wrap naturally at the array size.
  assign w_a1 = r_addr + ADDR_W'(1);
  assign w_a2 = r_addr + ADDR_W'(2);
  assign w_a3 = r_addr + ADDR_W'(3);
  assign w_b0 = r_mem[r_addr];
  assign w_b1 = r_mem[w_a1];
  assign w_b2 = r_mem[w_a2];
  assign w_b3 = r_mem[w_a3];

  assign w_fault = (r_type == 2'b11) ||
                   ((r_type == 2'b01) && r_addr[0]) ||
                   ((r_type == 2'b10) && (r_addr[1:0] != 2'b00));

  always_comb begin
    w_rdata = '0;
    case (r_type)
      2'b00:   w_rdata = {{24{r_se & w_b0[7]}}, w_b0};
      2'b01:   w_rdata = {{16{r_se & w_b0[7]}}, w_b0, w_b1};
      2'b10:   w_rdata = {w_b0, w_b1, w_b2, w_b3};
      default: w_rdata = '0;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_dout_nx  = r_dout;
    w_moc_nx   = r_moc;
    w_err_nx   = r_err;
    w_latch    = 1'b0;
    w_we       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (MOV) begin
          w_latch    = 1'b1;
          w_cnt_nx   = LpWait;
          w_state_nx = StBusy;
        end
      end
      StBusy: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nx = r_cnt - 4'd1;
        end else begin
          w_moc_nx   = 1'b1;
          w_state_nx = StDone;
          if (w_fault) begin
            w_err_nx  = 1'b1;
            w_dout_nx = '0;
          end else if (r_rw) begin
            w_dout_nx = w_rdata;
          end else begin
            w_we = 1'b1;
          end
        end
      end
      StDone: begin
        if (!MOV) begin
          w_moc_nx   = 1'b0;
          w_err_nx   = 1'b0;
          w_state_nx = StIdle;
        end
      end
      default: w_state_nx = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_moc   <= 1'b0;
      r_err   <= 1'b0;
      r_rw    <= 1'b0;
      r_se    <= 1'b0;
      r_type  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_dout  <= w_dout_nx;
      r_moc   <= w_moc_nx;
      r_err   <= w_err_nx;
      if (w_latch) begin
        r_rw    <= RW;
        r_se    <= SE;
        r_type  <= Type;
        r_addr  <= Address[ADDR_W-1:0];
        r_wdata <= DataIn;
      end
    end
  end

  // Array is deliberately outside the reset domain so contents survive Clr.
  always_ff @(posedge Clk) begin
    if (w_we) begin
      case (r_type)
        2'b00: r_mem[r_addr] <= r_wdata[7:0];
        2'b01: begin
          r_mem[r_addr] <= r_wdata[15:8];
          r_mem[w_a1]   <= r_wdata[7:0];
        end
        2'b10: begin
          r_mem[r_addr] <= r_wdata[31:24];
          r_mem[w_a1]   <= r_wdata[23:16];
          r_mem[w_a2]   <= r_wdata[15:8];
          r_mem[w_a3]   <= r_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  assign DataOut = r_dout;
  assign MOC     = r_moc;
  assign Err     = r_err;

endmodule

// File: doc/ram_moc_responder.md
Name: ram_moc_responder

Overview:
- Memory-side responder for the control unit's MOV/RW/MOC memory handshake.
- Accepts a request when the control unit raises MOV, with address from MAR, write data from MDR, and the access size.
- Performs a byte, halfword or word access on an internal big-endian byte array after a programmable number of wait states.
- Signals completion on MOC. It is the other end of the interface that the microprogram waits on in its fetch state and its load/store states.

Parameters:
- ADDR_W, 9, byte-address width of the internal array (2**ADDR_W bytes).
- WAIT_CYCLES, 2, wait states between request acceptance and completion (0..15).

Ports:
- Clk  input  1  system clock, rising edge.
- Clr  input  1  asynchronous active-low reset.
- MOV  input  1  memory operation valid (request), level held by the control unit.
- RW  input  1  1 = read, 0 = write.
- Type  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- SE  input  1  read sign-extend enable for byte/halfword reads.
- Address  input  32  byte address from MAR; only [ADDR_W-1:0] is used.
- DataIn  input  32  write data from MDR; right-justified for byte/halfword.
- DataOut  output  32  read data to MDR.
- MOC  output  1  memory operation complete.
- Err  output  1  access fault (misaligned or reserved Type), valid while MOC=1.

Behaviour:
- Reset (Clr=0, asynchronous):
  - State goes to IDLE; MOC=0, Err=0, DataOut=0, wait counter=0.
  - Array contents are not cleared.
  - A write not yet committed when reset asserts is discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On a posedge with MOV=1, latch RW, Type, SE, Address[ADDR_W-1:0] and DataIn.
  - Load the counter with WAIT_CYCLES and go to BUSY.
  - Inputs are ignored after this latch; changes during BUSY have no effect.
- BUSY:
  - If counter != 0: decrement at each posedge.
  - At the posedge where counter == 0: execute the access, set MOC=1, go to DONE.
  - Latency: MOC rises on the (WAIT_CYCLES+1)th posedge after the accepting edge.
- Access, performed at the completion edge:
  - Word at A uses bytes A..A+3; mem[A] is bits [31:24].
  - Halfword at A uses bytes A..A+1 and DataIn[15:0].
  - Byte at A uses DataIn[7:0].
  - Read: DataOut gets the assembled value, zero-extended, or sign-extended when SE=1.
  - Write: bytes are committed; DataOut is unchanged.
  - Address arithmetic wraps modulo 2**ADDR_W.
- Fault:
  - Condition: halfword with A[0]=1, word with A[1:0]!=0, or Type=11.
  - Response: no array write, DataOut=0, Err=1, and MOC=1 on the same edge as a normal completion.
- DONE:
  - MOC, Err and DataOut hold while MOV=1.
  - On the first posedge with MOV=0: MOC=0, Err=0, go to IDLE. DataOut keeps its last value.
  - A new request needs MOV low for at least one sampled edge. No back-to-back acceptance from DONE.
- MOV dropped during BUSY:
  - The operation still completes, and a write still commits.
  - DONE is entered with MOC=1, then the next posedge sees MOV=0 and returns to IDLE, giving a one-cycle MOC pulse.
- Reset mid-operation: an immediate return to IDLE, with no MOC pulse after release.

Test Plan:
- Word round trip, WAIT_CYCLES=2:
  - Write 0xDEADBEEF at 0x010 -> MOC rises 3 edges after acceptance, Err=0.
  - Drop MOV, then read 0x010 -> DataOut=0xDEADBEEF, with MOC held until MOV drops.
- Byte merge:
  - After the word write above, byte-write 0x5A at 0x013.
  - Word-read 0x010 -> 0xDEADBE5A.
  - Byte-read 0x010 with SE=1 -> 0xFFFFFFDE; with SE=0 -> 0x000000DE.
- Faults:
  - Halfword write at 0x011 -> Err=1 with MOC, DataOut=0; word-read 0x010 is unchanged.
  - Type=11 read -> Err=1.
- MOV dropped during BUSY on a write of 0x12345678 to 0x020 -> one-cycle MOC pulse, FSM back in IDLE; a later read of 0x020 returns 0x12345678.
- Reset: assert Clr=0 while BUSY on a write to 0x030 -> MOC=0 and Err=0 immediately; a subsequent read of 0x030 returns its prior value.
- Wrap and zero-wait, with ADDR_W=9 and WAIT_CYCLES=0:
  - Write 0xCAFEF00D at 0x200 -> MOC on the first edge after acceptance.
  - Read 0x000 -> 0xCAFEF00D.
